// File: rtl/sort_result_writer.sv
// sort_result_writer: terminal stage of the insertion-sort dataflow chain.
// It drains N words from the last cell's output FIFO and writes them to a
// single-port result RAM at addresses 0..N-1 in arrival order. It uses the
// ap_ctrl_chain block handshake (start/done/continue/idle/ready).
// Optional feature macro: SORT_CHECK_EN. When it is defined, a sticky order
// checker flags any word that breaks the expected sort direction (DESCEND).
// Without the macro, order_err is tied low and no checker logic is built.
module sort_result_writer #(
  parameter int DATA_W  = 32,
  parameter int N       = 8,
  parameter int ADDR_W  = 3,
  parameter int DESCEND = 0
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  input  logic              ap_continue,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DATA_W-1:0] in_V_dout,
  input  logic              in_V_empty_n,
  output logic              in_V_read,
  output logic [ADDR_W-1:0] out_r_address0,
  output logic              out_r_ce0,
  output logic              out_r_we0,
  output logic [DATA_W-1:0] out_r_d0,
  output logic              order_err
);

  // Reject parameter sets that cannot work: an empty transaction, a RAM too
  // small to hold N words, or an unknown sort direction.
  if (N < 1 || (2 ** ADDR_W) < N || DESCEND < 0 || DESCEND > 1) begin : g_param_check
    $error("sort_result_writer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_fire;
  logic              start_acc;

  // A word moves from the FIFO into the RAM only while running and the FIFO
  // has data; a new transaction is accepted only from IDLE.
  assign rd_fire   = (state_q == S_RUN) && in_V_empty_n;
  assign start_acc = (state_q == S_IDLE) && ap_start;

  // Next-state, write counter and all handshake / RAM port outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    ap_idle        = 1'b0;
    ap_ready       = 1'b0;
    ap_done        = 1'b0;
    in_V_read      = 1'b0;
    out_r_ce0      = 1'b0;
    out_r_we0      = 1'b0;
    out_r_address0 = '0;
    out_r_d0       = '0;
    case (state_q)
      S_IDLE: begin
        ap_idle = ~ap_start;
        if (ap_start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (in_V_empty_n) begin
          // Pop and RAM write land in the same cycle (zero write latency).
          in_V_read      = 1'b1;
          out_r_ce0      = 1'b1;
          out_r_we0      = 1'b1;
          out_r_address0 = cnt_q;
          out_r_d0       = in_V_dout;
          if (cnt_q == LAST_IDX) begin
            ap_ready = 1'b1;
            cnt_d    = '0;
            state_d  = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        // Further FIFO words stay queued until the next transaction.
        ap_done = 1'b1;
        if (ap_continue) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and write counter; reset aborts any transaction.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge values regardless of process ordering.
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SORT_CHECK_EN
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic                     order_err_q, order_err_d;
  logic                     viol;

  // Compare each word after the first against its predecessor; a violation
  // sets the sticky flag, and an accepted start clears it.
  always_comb begin
    prev_d      = prev_q;
    order_err_d = order_err_q;
    viol        = 1'b0;
    if (rd_fire && (cnt_q != '0)) begin
      if (DESCEND != 0) begin
        viol = $signed(in_V_dout) > prev_q;
      end else begin
        viol = $signed(in_V_dout) < prev_q;
      end
    end
    if (rd_fire) begin
      prev_d = $signed(in_V_dout);
    end
    if (start_acc) begin
      order_err_d = 1'b0;
    end else if (viol) begin
      order_err_d = 1'b1;
    end
  end

  // Previous-word register and sticky order-error flag.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      prev_q      <= '0;
      order_err_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      order_err_q <= order_err_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_sort_result_writer.sv
// Self-checking bench for sort_result_writer. The bench owns the input FIFO
// (a queue), logs every RAM write / ready / done event, and compares those
// logs with what the transaction rules predict for the pushed words.
module tb_sort_result_writer;
  localparam int DATA_W  = 32;
  localparam int N       = 8;
  localparam int ADDR_W  = 3;
  localparam int DESCEND = 0;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic              ap_continue = 1'b0;
  logic              ap_done, ap_idle, ap_ready;
  logic [DATA_W-1:0] in_V_dout = '0;
  logic              in_V_empty_n = 1'b0;
  logic              in_V_read;
  logic [ADDR_W-1:0] out_r_address0;
  logic              out_r_ce0, out_r_we0;
  logic [DATA_W-1:0] out_r_d0;
  logic              order_err;

  sort_result_writer #(
    .DATA_W (DATA_W),
    .N      (N),
    .ADDR_W (ADDR_W),
    .DESCEND(DESCEND)
  ) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .ap_start      (ap_start),
    .ap_done       (ap_done),
    .ap_continue   (ap_continue),
    .ap_idle       (ap_idle),
    .ap_ready      (ap_ready),
    .in_V_dout     (in_V_dout),
    .in_V_empty_n  (in_V_empty_n),
    .in_V_read     (in_V_read),
    .out_r_address0(out_r_address0),
    .out_r_ce0     (out_r_ce0),
    .out_r_we0     (out_r_we0),
    .out_r_d0      (out_r_d0),
    .order_err     (order_err)
  );

  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bench-side FIFO and the model's copy of the pushed word stream.
  logic [DATA_W-1:0] fifo[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                allow = 1'b1;
  bit                pop_flag = 1'b0;

  // Event logs filled by the monitor.
  int                wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];
  int                wr_cyc[$];
  int                ready_cyc[$];
  int                done_cyc[$];
  bit                err_seen = 1'b0;
  int                err_cyc = 0;

  task automatic refresh();
    in_V_empty_n = allow && (fifo.size() != 0);
    in_V_dout    = (fifo.size() != 0) ? fifo[0] : '0;
  endtask

  task automatic set_allow(input bit a);
    allow = a;
    refresh();
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    fifo.push_back(v);
    exp_q.push_back(v);
    refresh();
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    ready_cyc.delete();
    done_cyc.delete();
    err_seen = 1'b0;
  endtask

  // Advance one clock; pops the FIFO if the DUT read in the cycle just ended.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (pop_flag && fifo.size() != 0) void'(fifo.pop_front());
    pop_flag = 1'b0;
    refresh();
  endtask

  // Monitor: sample outputs mid-cycle and log transaction events.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      pop_flag = 1'b0;
    end else begin
      pop_flag = in_V_read;
      if (in_V_read || out_r_ce0 || out_r_we0) begin
        check("strobes", {29'd0, in_V_read, out_r_ce0, out_r_we0}, 32'd7);
        check("read_needs_data", {31'd0, in_V_empty_n}, 32'd1);
        check("wdata_is_head", out_r_d0, in_V_dout);
        wr_addr.push_back(int'(out_r_address0));
        wr_data.push_back(out_r_d0);
        wr_cyc.push_back(cyc);
      end else begin
        check("bus_quiet", {31'd0, (out_r_address0 != '0) || (out_r_d0 != '0)}, 32'd0);
      end
      if (ap_ready) ready_cyc.push_back(cyc);
      if (ap_done) begin
        done_cyc.push_back(cyc);
        check("no_read_in_done", {31'd0, in_V_read}, 32'd0);
      end
      if (order_err && !err_seen) begin
        err_seen = 1'b1;
        err_cyc  = cyc;
      end
    end
  end

  // One transaction of N words. mode 0: FIFO always ready; mode 1: empty_n
  // pattern 1,0,0,1; mode 2: random stalls. hold: cycles with continue low.
  task automatic run_txn(input int mode, input int hold, input string nm);
    int c0, k, viol_idx;
    int exp_cyc[$];
    logic [DATA_W-1:0] w[$];
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    check({nm, "_idle_before"}, {31'd0, ap_idle}, 32'd1);
    ap_start    = 1'b1;
    ap_continue = (hold == 0);
    #1;
    check({nm, "_idle_with_start"}, {31'd0, ap_idle}, 32'd0);
    c0 = cyc;
    tick();
    ap_start = 1'b0;
    clear_logs();
    check({nm, "_err_cleared"}, {31'd0, order_err}, 32'd0);

    k = 0;
    while (!ap_done && k < 400) begin
      case (mode)
        0:       set_allow(1'b1);
        1:       set_allow(pat[k % 4]);
        default: set_allow($urandom_range(0, 2) != 0);
      endcase
      if (allow) exp_cyc.push_back(c0 + 1 + k);
      tick();
      k++;
    end
    set_allow(1'b1);
    check({nm, "_done_reached"}, {31'd0, ap_done}, 32'd1);

    for (int i = 0; i < hold; i++) begin
      check({nm, "_done_held"}, {31'd0, ap_done}, 32'd1);
      tick();
    end
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    check({nm, "_done_released"}, {31'd0, ap_done}, 32'd0);
    check({nm, "_idle_after"}, {31'd0, ap_idle}, 32'd1);

    // Model: the first N pushed words, written to 0..N-1 in order.
    for (int i = 0; i < N; i++) w.push_back(exp_q.pop_front());
    check({nm, "_n_writes"}, wr_addr.size(), N);
    if (wr_addr.size() == N) begin
      for (int i = 0; i < N; i++) begin
        check({nm, "_addr"}, wr_addr[i], i);
        check({nm, "_data"}, wr_data[i], w[i]);
        // Writes happen exactly in the cycles where the FIFO offered data.
        if (mode != 2 && exp_cyc.size() > i) check({nm, "_wr_cycle"}, wr_cyc[i], exp_cyc[i]);
      end
      check({nm, "_n_ready"}, ready_cyc.size(), 1);
      if (ready_cyc.size() == 1) begin
        check({nm, "_ready_on_last"}, ready_cyc[0], wr_cyc[N-1]);
        check({nm, "_n_done"}, done_cyc.size(), hold + 1);
        if (done_cyc.size() != 0) check({nm, "_done_after_ready"}, done_cyc[0], ready_cyc[0] + 1);
      end
    end

    // Order model: first index whose word breaks the sort direction.
    viol_idx = -1;
    for (int i = 1; i < N; i++) begin
      if (viol_idx < 0 &&
          ((DESCEND == 0 && $signed(w[i]) < $signed(w[i-1])) ||
           (DESCEND != 0 && $signed(w[i]) > $signed(w[i-1]))))
        viol_idx = i;
    end
`ifdef SORT_CHECK_EN
    check({nm, "_err_flag"}, {31'd0, err_seen}, {31'd0, viol_idx >= 0});
    if (viol_idx >= 0 && err_seen && wr_cyc.size() == N) begin
      check({nm, "_err_cycle"}, err_cyc, wr_cyc[viol_idx] + 1);
      check({nm, "_err_sticky"}, {31'd0, order_err}, 32'd1);
    end
`else
    check({nm, "_err_tied_low"}, {31'd0, err_seen}, 32'd0);
`endif
  endtask

  initial begin
    int c0, k;

    // Power-on reset.
    refresh();
    #3;
    check("rst_done", {31'd0, ap_done}, 32'd0);
    check("rst_read", {31'd0, in_V_read}, 32'd0);
    check("rst_idle", {31'd0, ap_idle}, 32'd1);
    #9 ap_rst_n = 1'b1;
    tick();

    // Burst: 1..8 preloaded, continue high.
    for (int i = 1; i <= N; i++) push(DATA_W'(i));
    run_txn(0, 0, "burst");

    // Stall: empty_n toggles 1,0,0,1.
    for (int i = 0; i < N; i++) push(DATA_W'(100 + 3 * i));
    run_txn(1, 0, "stall");

    // Continue hold: two extra words must stay queued through DONE.
    for (int i = 0; i < N + 2; i++) push(DATA_W'(200 + i));
    run_txn(0, 5, "hold");
    check("hold_leftover", fifo.size(), 2);
    fifo.delete();
    exp_q.delete();
    refresh();

    // Back-to-back: start held high, 16 words queued.
    for (int i = 0; i < 2 * N; i++) push(DATA_W'(300 + i));
    ap_start    = 1'b1;
    ap_continue = 1'b1;
    c0 = cyc;
    clear_logs();
    for (int i = 0; i < 2 * N - 5; i++) tick();
    ap_start = 1'b0;
    k = 0;
    while (!ap_done && k < 100) begin
      tick();
      k++;
    end
    check("b2b_done_reached", {31'd0, ap_done}, 32'd1);
    tick();
    ap_continue = 1'b0;
    check("b2b_idle_after", {31'd0, ap_idle}, 32'd1);
    check("b2b_n_writes", wr_addr.size(), 2 * N);
    if (wr_addr.size() == 2 * N) begin
      for (int i = 0; i < 2 * N; i++) begin
        check("b2b_addr", wr_addr[i], i % N);
        check("b2b_data", wr_data[i], exp_q[i]);
        check("b2b_wr_cycle", wr_cyc[i], c0 + 1 + (i / N) * (N + 2) + (i % N));
      end
    end
    check("b2b_n_ready", ready_cyc.size(), 2);
    if (ready_cyc.size() == 2) check("b2b_period", ready_cyc[1] - ready_cyc[0], N + 2);
    check("b2b_n_done", done_cyc.size(), 2);
    exp_q.delete();

    // Order stream 2,5,5,3,... then a sorted stream -1,0,7,...
    push(32'd2); push(32'd5); push(32'd5); push(32'd3);
    push(32'd6); push(32'd7); push(32'd8); push(32'd9);
    run_txn(0, 0, "order_bad");
    push(-32'sd1); push(32'd0); push(32'd7); push(32'd7);
    push(32'd9); push(32'd10); push(32'd11); push(32'd12);
    run_txn(0, 0, "order_ok");

    // Randomized transactions: random or sorted data, random stalls and holds.
    for (int t = 0; t < 6; t++) begin
      int base;
      base = int'($urandom_range(0, 2000)) - 1000;
      for (int i = 0; i < N; i++) begin
        if (t % 2 == 0) push($urandom());
        else begin
          base = base + int'($urandom_range(0, 5));
          push(DATA_W'(base));
        end
      end
      run_txn(2, int'($urandom_range(0, 3)), "rand");
    end

    // Reset mid-RUN with cnt=3.
    for (int i = 0; i < N; i++) push(DATA_W'(500 + i));
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_addr", {29'd0, out_r_address0}, 32'd3);
    #2 ap_rst_n = 1'b0;
    #1;
    check("arst_done", {31'd0, ap_done}, 32'd0);
    check("arst_ready", {31'd0, ap_ready}, 32'd0);
    check("arst_read", {31'd0, in_V_read}, 32'd0);
    check("arst_ce_we", {30'd0, out_r_ce0, out_r_we0}, 32'd0);
    check("arst_addr", {29'd0, out_r_address0}, 32'd0);
    check("arst_d0", out_r_d0, 32'd0);
    check("arst_err", {31'd0, order_err}, 32'd0);
    check("arst_idle", {31'd0, ap_idle}, 32'd1);
    tick();
    check("arst_still_idle", {31'd0, ap_idle}, 32'd1);
    #2 ap_rst_n = 1'b1;
    fifo.delete();
    exp_q.delete();
    refresh();
    tick();
    check("post_rst_no_read", {31'd0, in_V_read}, 32'd0);

    // A clean transaction after the abort starts again at address 0.
    for (int i = 0; i < N; i++) push(DATA_W'(600 + i));
    run_txn(0, 0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
